// File: rtl/cordic_magnitude_pipe.sv
// Fully pipelined CORDIC vectoring engine: |(X,Y)| with valid/ready flow control and a global stall.
// Optional phase output is built when CORDIC_PHASE_EN is defined.
module cordic_magnitude_pipe #(
   parameter int unsigned IN_W  = 12,
   parameter int unsigned ITER  = 11,
   parameter int unsigned GUARD = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [IN_W-1:0] i_x,
   input  logic [IN_W-1:0] i_y,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [IN_W:0]   o_magnitude
`ifdef CORDIC_PHASE_EN
   ,
   output logic [15:0]     o_phase
`endif
);

   // Two headroom bits: the vector grows by up to sqrt(2) * 1.647 through the rotations.
   localparam int unsigned DW = IN_W + GUARD + 2;
   localparam int unsigned PW = DW + 11;
   localparam int unsigned SH = GUARD + 11;

   logic                 w_adv;
   logic                 r_out_valid;
   logic [IN_W:0]        r_mag;
   logic signed [DW-1:0] w_xs, w_ys, w_x0, w_y0;
   logic signed [DW-1:0] r_x  [0:ITER];
   logic signed [DW-1:0] w_xn [0:ITER];
   logic signed [DW-1:0] r_y  [0:ITER-1];
   logic signed [DW-1:0] w_yn [0:ITER-1];
   logic                 r_v  [0:ITER];
   logic                 w_vn [0:ITER];
   logic signed [PW-1:0] w_xe, w_prod;
   logic [IN_W:0]        w_mag;

   assign w_adv       = !r_out_valid || i_out_ready;
   assign o_in_ready  = w_adv;
   assign o_out_valid = r_out_valid;
   assign o_magnitude = r_mag;

   assign w_xs = DW'($signed(i_x));
   assign w_ys = DW'($signed(i_y));
   assign w_x0 = (w_xs[DW-1] ? -w_xs : w_xs) <<< GUARD;
   assign w_y0 = (w_ys[DW-1] ? -w_ys : w_ys) <<< GUARD;

   always_comb begin
      w_xn = '{default: '0};
      w_yn = '{default: '0};
      w_vn = '{default: 1'b0};
      w_xn[0] = w_x0;
      w_yn[0] = w_y0;
      w_vn[0] = i_in_valid;
      for (int s = 1; s <= int'(ITER); s++) begin
         w_vn[s] = r_v[s-1];
         if (!r_y[s-1][DW-1]) w_xn[s] = r_x[s-1] + (r_y[s-1] >>> (s - 1));
         else                 w_xn[s] = r_x[s-1] - (r_y[s-1] >>> (s - 1));
      end
      // Y after the last rotation is never consumed, so its stage is not built.
      for (int s = 1; s < int'(ITER); s++) begin
         if (!r_y[s-1][DW-1]) w_yn[s] = r_y[s-1] - (r_x[s-1] >>> (s - 1));
         else                 w_yn[s] = r_y[s-1] + (r_x[s-1] >>> (s - 1));
      end
   end

   // Gain compensation x*1243 as shift-add, rounded from full guard precision.
   assign w_xe   = PW'(r_x[ITER]);
   assign w_prod = (w_xe <<< 10) + (w_xe <<< 7) + (w_xe <<< 6) + (w_xe <<< 4)
                 + (w_xe <<< 3) + (w_xe <<< 1) + w_xe + PW'(1 << (SH - 1));
   assign w_mag  = (IN_W+1)'(w_prod >>> SH);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x         <= '{default: '0};
         r_y         <= '{default: '0};
         r_v         <= '{default: 1'b0};
         r_out_valid <= 1'b0;
         r_mag       <= '0;
      end else if (w_adv) begin
         r_x         <= w_xn;
         r_y         <= w_yn;
         r_v         <= w_vn;
         r_out_valid <= r_v[ITER];
         r_mag       <= w_mag;
      end
   end

`ifdef CORDIC_PHASE_EN
   logic [15:0] r_z  [0:ITER];
   logic [15:0] w_zn [0:ITER];
   logic [ITER:0] r_sx, r_sy;
   logic [15:0] r_phase, w_phase;

   function automatic logic [15:0] atan_lut(input int i);
      case (i)
         0:       atan_lut = 16'd8192;
         1:       atan_lut = 16'd4836;
         2:       atan_lut = 16'd2555;
         3:       atan_lut = 16'd1297;
         4:       atan_lut = 16'd651;
         5:       atan_lut = 16'd326;
         6:       atan_lut = 16'd163;
         7:       atan_lut = 16'd81;
         8:       atan_lut = 16'd41;
         9:       atan_lut = 16'd20;
         10:      atan_lut = 16'd10;
         11:      atan_lut = 16'd5;
         12:      atan_lut = 16'd3;
         13:      atan_lut = 16'd1;
         14:      atan_lut = 16'd1;
         default: atan_lut = 16'd0;
      endcase
   endfunction

   always_comb begin
      w_zn    = '{default: '0};
      for (int s = 1; s <= int'(ITER); s++) begin
         if (!r_y[s-1][DW-1]) w_zn[s] = r_z[s-1] + atan_lut(s - 1);
         else                 w_zn[s] = r_z[s-1] - atan_lut(s - 1);
      end
      w_phase = r_z[ITER];
      unique case ({r_sx[ITER], r_sy[ITER]})
         2'b00: w_phase = r_z[ITER];
         2'b10: w_phase = 16'd32768 - r_z[ITER];
         2'b11: w_phase = 16'd32768 + r_z[ITER];
         2'b01: w_phase = 16'd0 - r_z[ITER];
         default: w_phase = r_z[ITER];
      endcase
   end

   assign o_phase = r_phase;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_z     <= '{default: '0};
         r_sx    <= '0;
         r_sy    <= '0;
         r_phase <= '0;
      end else if (w_adv) begin
         r_z     <= w_zn;
         r_sx    <= {r_sx[ITER-1:0], i_x[IN_W-1]};
         r_sy    <= {r_sy[ITER-1:0], i_y[IN_W-1]};
         r_phase <= w_phase;
      end
   end
`endif

endmodule
